regfile_mp: RTL

- Parametrised multi-port integer register file for the next CPU core generation; replaces the single-write/dual-read file in the decode/writeback path.
- Adds configurable width/depth, N read ports, two write ports (ALU and load/SoC writeback), optional write-to-read bypass, and a register scoreboard (pending bits) for hazard detection.
- Sits between decode (read/alloc) and writeback (write/clear).

---
 rtl/regfile_mp_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 70 +++++++
 rtl/regfile_mp.sv | 102 ++++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port integer register file.
// Default geometry and the hardwired-zero register index.
package regfile_mp_pkg;

    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned NRD_DEF  = 2;
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Register scoreboard: pending bits set at issue, cleared at writeback.
// Tracks the pending population and flags double allocation.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              clr0_i,
    input  logic [AW-1:0]     clr0_addr_i,
    input  logic              clr1_i,
    input  logic [AW-1:0]     clr1_addr_i,
    output logic [2**AW-1:0]  pending_o,
    output logic [AW:0]       busy_cnt_o,
    output logic              err_o
);

    localparam int unsigned DEPTH = 2**AW;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             err_q, err_d;

    logic hit0, hit1, same01;
    logic set_new, dec0, dec1;

    assign hit0   = set_i && clr0_i && (set_addr_i == clr0_addr_i);
    assign hit1   = set_i && clr1_i && (set_addr_i == clr1_addr_i);
    assign same01 = clr0_i && clr1_i && (clr0_addr_i == clr1_addr_i);

    // Only transitions that actually flip a bit move the count.
    assign set_new = set_i && !pending_q[set_addr_i];
    assign dec0    = clr0_i && pending_q[clr0_addr_i] && !hit0;
    assign dec1    = clr1_i && pending_q[clr1_addr_i] && !hit1 && !same01;

    always_comb begin
        pending_d = pending_q;
        if (clr0_i) pending_d[clr0_addr_i] = 1'b0;
        if (clr1_i) pending_d[clr1_addr_i] = 1'b0;
        if (set_i)  pending_d[set_addr_i]  = 1'b1;

        cnt_d = cnt_q + (AW+1)'(set_new)
                      - (AW+1)'(dec0)
                      - (AW+1)'(dec1);

        err_d = err_q;
        if (set_i && pending_q[set_addr_i] && !hit0 && !hit1)
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign pending_o  = pending_q;
    assign busy_cnt_o = cnt_q;
    assign err_o      = err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational reads, two writes,
// optional write-to-read bypass and a pending-register scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NRD    = NRD_DEF,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_ready,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata1,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [AW:0]       busy_cnt,
    output logic              err_o
);

    localparam int unsigned  DEPTH = 2**AW;
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             wr0, wr1, alloc;

    assign wr0   = we0 && (waddr0 != ZERO);
    assign wr1   = we1 && (waddr1 != ZERO);
    assign alloc = alloc_en && (alloc_addr != ZERO);

    // Port 1 applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0) regs_d[waddr0] = wdata0;
        if (wr1) regs_d[waddr1] = wdata1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .AW (AW)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_i       (alloc),
        .set_addr_i  (alloc_addr),
        .clr0_i      (wr0),
        .clr0_addr_i (waddr0),
        .clr1_i      (wr1),
        .clr1_addr_i (waddr1),
        .pending_o   (pending),
        .busy_cnt_o  (busy_cnt),
        .err_o       (err_o)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rdat;
        logic          rrdy;

        assign ra = rd_addr[i*AW +: AW];

        // Bypass is held off during reset so reads stay zero.
        always_comb begin
            rdat = regs_q[ra];
            rrdy = !pending[ra];
            if (ra == ZERO) begin
                rdat = '0;
                rrdy = 1'b1;
            end else if (BYPASS && !rst_i) begin
                if (wr0 && (waddr0 == ra)) begin
                    rdat = wdata0;
                    rrdy = 1'b1;
                end
                if (wr1 && (waddr1 == ra)) begin
                    rdat = wdata1;
                    rrdy = 1'b1;
                end
            end
        end

        assign rd_data[i*DW +: DW] = rdat;
        assign rd_ready[i]         = rrdy;
    end

endmodule
